regbank_access_ctrl: RTL and testbench

- Initiator for the RegisterBank port set (dest, Din, srcadd1, srcadd2 -> src1, src2).
- Accepts issue requests (rd, rs1, rs2) from decode and fetches both source operands from the bank. Hands the operands downstream through a valid/ready handshake.
- Forwards execute-stage writebacks into the bank write port.
- Holds a per-register busy scoreboard so that no operand is read before its pending producer has written it back.

---
 rtl/regbank_access_ctrl_pkg.sv | 7 +
 rtl/regbank_access_ctrl_if.sv | 33 +++
 rtl/regbank_access_ctrl_scoreboard.sv | 31 +++
 rtl/regbank_access_ctrl.sv | 68 ++++++
 tb/tb_regbank_access_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regbank_access_ctrl_pkg.sv
// regbank_pkg: shared widths and controller state encoding for the register-bank access controller
package regbank_pkg;
  localparam int AW = 4;
  localparam int NREG = 2 ** AW;
  localparam int DW = 32;
  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;
endpackage

// File: rtl/regbank_access_ctrl_if.sv
// regbank_access_ctrl_if: issue, operand, writeback and register-bank signals of the access controller
interface regbank_access_ctrl_if;
  import regbank_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic [AW-1:0] in_rd;
  logic in_wr;
  logic out_valid;
  logic out_ready;
  logic [DW-1:0] out_op1;
  logic [DW-1:0] out_op2;
  logic [AW-1:0] out_rd;
  logic wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic we;
  logic [AW-1:0] dest;
  logic [DW-1:0] Din;
  logic [AW-1:0] srcadd1;
  logic [AW-1:0] srcadd2;
  logic [DW-1:0] src1;
  logic [DW-1:0] src2;
  modport slave (
    input in_valid, in_rs1, in_rs2, in_rd, in_wr, out_ready, wb_valid, wb_rd, wb_data, src1, src2,
    output in_ready, out_valid, out_op1, out_op2, out_rd, we, dest, Din, srcadd1, srcadd2
  );
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_wr, out_ready, wb_valid, wb_rd, wb_data, src1, src2,
    input in_ready, out_valid, out_op1, out_op2, out_rd, we, dest, Din, srcadd1, srcadd2
  );
endinterface

// File: rtl/regbank_access_ctrl_scoreboard.sv
// regbank_scoreboard: per-register busy bits; a same-cycle writeback already counts as cleared for hazard queries
module regbank_scoreboard
  import regbank_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_set,
  input  logic [AW-1:0] i_set_rd,
  input  logic i_clr,
  input  logic [AW-1:0] i_clr_rd,
  input  logic [AW-1:0] i_q1,
  input  logic [AW-1:0] i_q2,
  input  logic [AW-1:0] i_qw,
  output logic o_haz1,
  output logic o_haz2,
  output logic o_hazw
);
  logic [NREG-1:0] r_busy, w_set, w_clr, w_pend;
  always_comb begin
    w_set = i_set ? {{(NREG-1){1'b0}}, 1'b1} << i_set_rd : '0;
    w_clr = i_clr ? {{(NREG-1){1'b0}}, 1'b1} << i_clr_rd : '0;
    w_pend = r_busy & ~w_clr;
    o_haz1 = w_pend[i_q1];
    o_haz2 = w_pend[i_q2];
    o_hazw = w_pend[i_qw];
  end
  // set after clear so a new producer wins over a retiring one on the same register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_busy <= '0;
    else r_busy <= w_pend | w_set;
endmodule

// File: rtl/regbank_access_ctrl.sv
// regbank_access_ctrl: fetches issue operands from the register bank, stalling on pending writebacks
module regbank_access_ctrl
  import regbank_pkg::*;
(
  input logic clk,
  input logic rst_n,
  regbank_access_ctrl_if.slave bus
);
  state_t r_state, w_next;
  logic [AW-1:0] r_srcadd1, r_srcadd2, r_out_rd;
  logic [DW-1:0] r_op1, r_op2, w_op1, w_op2;
  logic w_haz1, w_haz2, w_hazw, w_ready, w_accept;
  regbank_scoreboard u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .i_set(w_accept && bus.in_wr),
    .i_set_rd(bus.in_rd),
    .i_clr(bus.wb_valid),
    .i_clr_rd(bus.wb_rd),
    .i_q1(bus.in_rs1),
    .i_q2(bus.in_rs2),
    .i_qw(bus.in_rd),
    .o_haz1(w_haz1),
    .o_haz2(w_haz2),
    .o_hazw(w_hazw)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (w_accept ? READ : IDLE) :
             r_state == READ ? HOLD : (bus.out_ready ? IDLE : HOLD);
  // the bank commits a writeback on the read edge, so a matching writeback bypasses the stale bank value
  always_comb begin
    w_ready = r_state == IDLE && !w_haz1 && !w_haz2 && !(bus.in_wr && w_hazw);
    w_accept = bus.in_valid && w_ready;
    w_op1 = bus.wb_valid && bus.wb_rd == r_srcadd1 ? bus.wb_data : bus.src1;
    w_op2 = bus.wb_valid && bus.wb_rd == r_srcadd2 ? bus.wb_data : bus.src2;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_srcadd1 <= '0;
      r_srcadd2 <= '0;
      r_out_rd <= '0;
      r_op1 <= '0;
      r_op2 <= '0;
    end else begin
      if (w_accept) begin
        r_srcadd1 <= bus.in_rs1;
        r_srcadd2 <= bus.in_rs2;
        r_out_rd <= bus.in_rd;
      end
      if (r_state == READ) begin
        r_op1 <= w_op1;
        r_op2 <= w_op2;
      end
    end
  assign bus.in_ready = w_ready;
  assign bus.out_valid = r_state == HOLD;
  assign bus.out_op1 = r_op1;
  assign bus.out_op2 = r_op2;
  assign bus.out_rd = r_out_rd;
  assign bus.srcadd1 = r_srcadd1;
  assign bus.srcadd2 = r_srcadd2;
  assign bus.we = bus.wb_valid;
  assign bus.dest = bus.wb_rd;
  assign bus.Din = bus.wb_data;
endmodule

// File: tb/tb_regbank_access_ctrl.sv
// tb_regbank_access_ctrl: directed issue/writeback scenarios against a transaction-level model of the controller
module tb_regbank_access_ctrl;
  logic clk = 0;
  logic rst_n = 1;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  regbank_access_ctrl_if bus();
  regbank_access_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [31:0] bank [16];
  always @(posedge clk) if (bus.we) bank[bus.dest] <= bus.Din;
  assign bus.src1 = bank[bus.srcadd1];
  assign bus.src2 = bank[bus.srcadd2];
  logic [31:0] m_bank [16];
  bit [15:0] m_busy;
  bit m_pend, m_valid;
  logic [3:0] m_rs1, m_rs2, m_rd;
  logic [31:0] e_op1, e_op2;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit haz(input logic [3:0] r);
    return m_busy[r] && !(bus.wb_valid && bus.wb_rd == r);
  endfunction
  function automatic bit m_ready();
    return !m_pend && !m_valid && !haz(bus.in_rs1) && !haz(bus.in_rs2) && !(bus.in_wr && haz(bus.in_rd));
  endfunction
  function automatic logic [31:0] landed(input logic [3:0] r);
    return (bus.wb_valid && bus.wb_rd == r) ? bus.wb_data : m_bank[r];
  endfunction
  // one transaction at a time: accepted -> read pending for one cycle -> valid until taken
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 0;
      m_valid <= 0;
      m_busy <= '0;
      m_rs1 <= '0;
      m_rs2 <= '0;
      m_rd <= '0;
      e_op1 <= '0;
      e_op2 <= '0;
    end else begin
      if (bus.wb_valid) m_bank[bus.wb_rd] <= bus.wb_data;
      if (m_pend) begin
        e_op1 <= landed(m_rs1);
        e_op2 <= landed(m_rs2);
        m_valid <= 1;
        m_pend <= 0;
      end else if (m_valid && bus.out_ready) m_valid <= 0;
      if (bus.wb_valid) m_busy[bus.wb_rd] <= 0;
      if (bus.in_valid && m_ready()) begin
        m_pend <= 1;
        m_rs1 <= bus.in_rs1;
        m_rs2 <= bus.in_rs2;
        m_rd <= bus.in_rd;
        if (bus.in_wr) m_busy[bus.in_rd] <= 1;
      end
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_ops", 64'({bus.out_op1, bus.out_op2}), 64'(0));
      chk("rst_addr_rd", 64'({bus.srcadd1, bus.srcadd2, bus.out_rd}), 64'(0));
    end else begin
      chk("in_ready", 64'(bus.in_ready), 64'(m_ready()));
      chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
      chk("srcadd", 64'({bus.srcadd1, bus.srcadd2}), 64'({m_rs1, m_rs2}));
      chk("wr_port", 64'({bus.we, bus.dest, bus.Din}), 64'({bus.wb_valid, bus.wb_rd, bus.wb_data}));
      if (m_valid) begin
        chk("out_op1", 64'(bus.out_op1), 64'(e_op1));
        chk("out_op2", 64'(bus.out_op2), 64'(e_op2));
        chk("out_rd", 64'(bus.out_rd), 64'(m_rd));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wb(input logic [3:0] r, input logic [31:0] d);
    bus.wb_valid = 1;
    bus.wb_rd = r;
    bus.wb_data = d;
    tick();
    bus.wb_valid = 0;
  endtask
  task automatic set_in(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d, input logic w);
    bus.in_valid = 1;
    bus.in_rs1 = s1;
    bus.in_rs2 = s2;
    bus.in_rd = d;
    bus.in_wr = w;
  endtask
  // returns just after the accept edge, i.e. during the read cycle
  task automatic issue(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d, input logic w);
    int n = 0;
    set_in(s1, s2, d, w);
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("issue_accept", 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_valid = 0;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      bank[i] = 32'hB000_0000 + i;
      m_bank[i] = 32'hB000_0000 + i;
    end
    bus.in_valid = 0;
    bus.in_rs1 = 0;
    bus.in_rs2 = 0;
    bus.in_rd = 0;
    bus.in_wr = 0;
    bus.out_ready = 1;
    bus.wb_valid = 0;
    bus.wb_rd = 0;
    bus.wb_data = 0;
    #1 rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    set_in(0, 0, 0, 0);
    @(negedge clk);
    chk("post_reset_ready", 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_valid = 0;
    tick();
    tick();
    wb(1, 32'h11);
    wb(2, 32'h22);
    issue(1, 2, 5, 1);
    tick();
    @(negedge clk);
    chk("basic_valid", 64'(bus.out_valid), 64'(1));
    chk("basic_op1", 64'(bus.out_op1), 64'(32'h11));
    chk("basic_op2", 64'(bus.out_op2), 64'(32'h22));
    chk("basic_rd", 64'(bus.out_rd), 64'(5));
    tick();
    set_in(5, 0, 6, 0);
    repeat (3) begin
      @(negedge clk);
      chk("raw_stall", 64'(bus.in_ready), 64'(0));
    end
    tick();
    bus.wb_valid = 1;
    bus.wb_rd = 5;
    bus.wb_data = 32'hABCD;
    @(negedge clk);
    chk("raw_release", 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_valid = 0;
    bus.wb_valid = 0;
    tick();
    @(negedge clk);
    chk("raw_op1", 64'(bus.out_op1), 64'(32'hABCD));
    tick();
    issue(7, 1, 0, 0);
    bus.wb_valid = 1;
    bus.wb_rd = 7;
    bus.wb_data = 32'h1234;
    tick();
    bus.wb_valid = 0;
    @(negedge clk);
    chk("bypass_op1", 64'(bus.out_op1), 64'(32'h1234));
    chk("bypass_op2", 64'(bus.out_op2), 64'(32'h11));
    tick();
    bus.out_ready = 0;
    issue(3, 4, 8, 0);
    tick();
    set_in(0, 0, 0, 0);
    repeat (4) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.out_valid), 64'(1));
      chk("bp_op1", 64'(bus.out_op1), 64'(32'hB000_0003));
      chk("bp_op2", 64'(bus.out_op2), 64'(32'hB000_0004));
      chk("bp_ready", 64'(bus.in_ready), 64'(0));
    end
    tick();
    bus.out_ready = 1;
    tick();
    bus.in_valid = 0;
    @(negedge clk);
    chk("bp_release_valid", 64'(bus.out_valid), 64'(0));
    chk("bp_release_ready", 64'(bus.in_ready), 64'(1));
    tick();
    issue(0, 0, 4, 1);
    tick();
    tick();
    set_in(0, 0, 4, 1);
    @(negedge clk);
    chk("waw_stall", 64'(bus.in_ready), 64'(0));
    tick();
    bus.wb_valid = 1;
    bus.wb_rd = 4;
    bus.wb_data = 32'h44;
    @(negedge clk);
    chk("collide_ready", 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_valid = 0;
    bus.wb_valid = 0;
    tick();
    tick();
    set_in(4, 0, 0, 0);
    @(negedge clk);
    chk("collide_still_busy", 64'(bus.in_ready), 64'(0));
    tick();
    bus.wb_valid = 1;
    bus.wb_rd = 4;
    bus.wb_data = 32'h55;
    @(negedge clk);
    chk("collide_release", 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_valid = 0;
    bus.wb_valid = 0;
    tick();
    @(negedge clk);
    chk("collide_op1", 64'(bus.out_op1), 64'(32'h55));
    tick();
    issue(6, 6, 6, 1);
    tick();
    tick();
    issue(0, 0, 3, 1);
    rst_n = 0;
    @(negedge clk);
    chk("mid_read_reset_valid", 64'(bus.out_valid), 64'(0));
    tick();
    set_in(3, 3, 9, 0);
    rst_n = 1;
    @(negedge clk);
    chk("mid_read_reset_ready", 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_valid = 0;
    tick();
    @(negedge clk);
    chk("same_src_op1", 64'(bus.out_op1), 64'(32'hB000_0003));
    chk("same_src_op2", 64'(bus.out_op2), 64'(32'hB000_0003));
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
